scan_sequencer: RTL and testbench

Cyclic channel scanner that drives the select (`x`) and enable (`en`) inputs of the 2-to-4 decoder stage directly downstream. It steps through four channels at a programmable dwell rate and skips masked-out channels. It inserts a dead-time interval with `en` low between channels, so consecutive decoder outputs never overlap. A one-cycle `frame_done` pulse marks completion of each full scan; it is used by display-multiplex and row-scan logic.

---
 rtl/scan_sequencer.sv | 158 +++++++++++++++
 tb/tb_scan_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/scan_sequencer.sv
// scan_sequencer
//   Cyclic four-channel scanner that drives the select/enable pair of a
//   downstream 2-to-4 decoder. Each enabled channel gets an active slot of
//   div+1 cycles. Consecutive slots are separated by BLANK_CYCLES cycles with
//   en low, so two decoder outputs are never high at the same time.
//   frame_done pulses for one cycle on the first active cycle of each new frame.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   run        in   scan enable; dropping it returns to IDLE on the next edge
//   div        in   dwell length; an active slot lasts div+1 cycles
//   mask       in   channel enables; sampled only when a slot is selected
//   x          out  channel select (registered)
//   en         out  decoder enable (registered)
//   frame_done out  one-cycle frame pulse (registered)
module scan_sequencer #(
  parameter int DIV_WIDTH    = 8,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [3:0]           mask,
  output logic [1:0]           x,
  output logic                 en,
  output logic                 frame_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    BLANK  = 2'd2
  } state_t;

  // The blank counter runs 0..BLANK_CYCLES-1. It keeps at least one bit so
  // the design still elaborates when there is no dead time.
  localparam int            BW         = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

  state_t               state_q, state_d;
  logic [DIV_WIDTH-1:0] dwell_cnt, dwell_d;
  logic [BW-1:0]        blank_cnt, blank_d;
  logic [1:0]           x_d;
  logic                 en_d;
  logic                 fd_d;
  logic                 adv;
  logic [2:0]           sel;

  // Returns {found, index} for the first set bit of m, searching from cur+1
  // with modulo-4 wrap. The last candidate is cur itself. Passing cur=3
  // therefore yields the lowest set bit.
  function automatic logic [2:0] next_set(input logic [3:0] m, input logic [1:0] cur);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int i = 1; i <= 4; i++) begin
      idx = cur + 2'(i);
      if (!r[2] && m[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    x_d     = x;
    en_d    = en;
    fd_d    = 1'b0;
    dwell_d = dwell_cnt;
    blank_d = blank_cnt;
    adv     = 1'b0;
    sel     = 3'b000;

    case (state_q)
      IDLE: begin
        x_d  = 2'b00;
        en_d = 1'b0;
        if (mask != 4'b0000) begin
          sel     = next_set(mask, 2'd3);
          state_d = ACTIVE;
          x_d     = sel[1:0];
          en_d    = 1'b1;
          dwell_d = '0;
        end
      end
      ACTIVE: begin
        // An equality exit means a div lowered below the count runs until wrap.
        if (dwell_cnt == div) begin
          if (BLANK_CYCLES == 0) begin
            adv = 1'b1;
          end else begin
            state_d = BLANK;
            en_d    = 1'b0;
            blank_d = '0;
          end
        end else begin
          dwell_d = dwell_cnt + 1'b1;
        end
      end
      BLANK: begin
        if (blank_cnt == BLANK_LAST) adv = 1'b1;
        else                         blank_d = blank_cnt + 1'b1;
      end
      default: begin
        state_d = IDLE;
        x_d     = 2'b00;
        en_d    = 1'b0;
      end
    endcase

    if (adv) begin
      sel = next_set(mask, x);
      if (sel[2]) begin
        state_d = ACTIVE;
        x_d     = sel[1:0];
        en_d    = 1'b1;
        dwell_d = '0;
        // A wrap, or landing back on the same lone channel, starts a new frame.
        fd_d    = (sel[1:0] <= x);
      end else begin
        state_d = IDLE;
        x_d     = 2'b00;
        en_d    = 1'b0;
        dwell_d = '0;
        blank_d = '0;
      end
    end

    if (!run) begin
      state_d = IDLE;
      x_d     = 2'b00;
      en_d    = 1'b0;
      fd_d    = 1'b0;
      dwell_d = '0;
      blank_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      x          <= 2'b00;
      en         <= 1'b0;
      frame_done <= 1'b0;
      dwell_cnt  <= '0;
      blank_cnt  <= '0;
    end else begin
      state_q    <= state_d;
      x          <= x_d;
      en         <= en_d;
      frame_done <= fd_d;
      dwell_cnt  <= dwell_d;
      blank_cnt  <= blank_d;
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Testbench for scan_sequencer (DIV_WIDTH=8, BLANK_CYCLES=2).
// Each table row holds the inputs applied before one rising edge and the
// x/en/frame_done values expected just after that edge.
module tb_scan_sequencer;

  logic       clk;
  logic       rst;
  logic       run;
  logic [7:0] div;
  logic [3:0] mask;
  logic [1:0] x;
  logic       en;
  logic       frame_done;

  scan_sequencer #(.DIV_WIDTH(8), .BLANK_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .div        (div),
    .mask       (mask),
    .x          (x),
    .en         (en),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       run;
    logic [7:0] div;
    logic [3:0] mask;
    logic [1:0] ex;
    logic       een;
    logic       efd;
  } vec_t;

  vec_t  vq[$];
  string sect;
  int    n_tests;
  int    n_fail;

  task automatic add(input logic r, input logic ru, input logic [7:0] d,
                     input logic [3:0] m, input logic [1:0] ex,
                     input logic een, input logic efd);
    vec_t v;
    v.name = sect;
    v.rst  = r;
    v.run  = ru;
    v.div  = d;
    v.mask = m;
    v.ex   = ex;
    v.een  = een;
    v.efd  = efd;
    vq.push_back(v);
  endtask

  // Expected waveform of an uninterrupted scan started from IDLE. The cycle
  // numbering c starts at 1 on the first active cycle. Slot s covers cycles
  // with (c-1)/(d+3) == s. The channel order is packed two bits per slot
  // into chans, and n is the number of enabled channels.
  task automatic add_scan(input int c0, input int ncyc, input logic [3:0] m,
                          input logic [7:0] d, input logic [7:0] chans, input int n);
    int len, s, pos;
    logic [1:0] ch;
    len = int'(d) + 3;
    for (int c = c0; c < c0 + ncyc; c++) begin
      s   = (c - 1) / len;
      pos = (c - 1) % len;
      ch  = chans[2*(s % n) +: 2];
      add(1'b0, 1'b1, d, m, ch, pos <= int'(d), (pos == 0) && (s > 0) && (s % n == 0));
    end
  endtask

  initial begin
    logic prev_fd;
    n_tests = 0;
    n_fail  = 0;
    prev_fd = 1'b0;
    rst  = 1'b1;
    run  = 1'b0;
    div  = 8'd0;
    mask = 4'b0000;

    sect = "reset";
    for (int i = 0; i < 3; i++) add(1, 1, 8'd3, 4'hF, 2'd0, 0, 0);

    sect = "full_scan";
    add_scan(1, 50, 4'hF, 8'd3, 8'b11_10_01_00, 4);
    sect = "stop_a";
    add(0, 0, 8'd3, 4'hF, 2'd0, 0, 0);

    sect = "masked_skip";
    add_scan(1, 12, 4'hA, 8'd0, 8'b00_00_11_01, 2);
    sect = "stop_b";
    add(0, 0, 8'd0, 4'hA, 2'd0, 0, 0);

    sect = "single_ch";
    add_scan(1, 12, 4'h4, 8'd1, 8'b00_00_00_10, 1);
    sect = "stop_c";
    add(0, 0, 8'd1, 4'h4, 2'd0, 0, 0);

    // Cycle 14 is the second active cycle on channel 2. Run is low at the
    // edge that ends it.
    sect = "pre_stop";
    add_scan(1, 14, 4'hF, 8'd3, 8'b11_10_01_00, 4);
    sect = "stop_mid_slot";
    add(0, 0, 8'd3, 4'hF, 2'd0, 0, 0);
    sect = "restart";
    add_scan(1, 7, 4'hF, 8'd3, 8'b11_10_01_00, 4);

    // The mask clears while channel 1 is active. That slot and its blank
    // still complete, and the scan then drops to IDLE without a frame pulse.
    sect = "empty_mask_slot";
    for (int i = 0; i < 3; i++) add(0, 1, 8'd3, 4'h0, 2'd1, 1, 0);
    sect = "empty_mask_blank";
    for (int i = 0; i < 2; i++) add(0, 1, 8'd3, 4'h0, 2'd1, 0, 0);
    sect = "empty_mask_idle";
    for (int i = 0; i < 3; i++) add(0, 1, 8'd3, 4'h0, 2'd0, 0, 0);

    sect = "mask1_restart";
    for (int i = 0; i < 4; i++) add(0, 1, 8'd3, 4'h1, 2'd0, 1, 0);
    for (int i = 0; i < 2; i++) add(0, 1, 8'd3, 4'h1, 2'd0, 0, 0);
    add(0, 1, 8'd3, 4'h1, 2'd0, 1, 1);
    add(0, 1, 8'd3, 4'h1, 2'd0, 1, 0);

    sect = "reset_mid_slot";
    add(1, 1, 8'd3, 4'h1, 2'd0, 0, 0);
    sect = "after_reset";
    add(0, 1, 8'd3, 4'h1, 2'd0, 1, 0);

    for (int i = 0; i < vq.size(); i++) begin
      rst  = vq[i].rst;
      run  = vq[i].run;
      div  = vq[i].div;
      mask = vq[i].mask;
      @(posedge clk);
      #1;
      n_tests++;
      if ({x, en, frame_done} !== {vq[i].ex, vq[i].een, vq[i].efd}) begin
        n_fail++;
        $display("FAIL %s row %0d: got x=%0d en=%b fd=%b, expected x=%0d en=%b fd=%b",
                 vq[i].name, i, x, en, frame_done, vq[i].ex, vq[i].een, vq[i].efd);
      end
      n_tests++;
      if ((prev_fd & frame_done) !== 1'b0) begin
        n_fail++;
        $display("FAIL fd_back_to_back row %0d: got fd=%b twice, expected no repeat",
                 i, frame_done);
      end
      prev_fd = frame_done;
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
